// File: rtl/axil_arb_pkg.sv
// rtl/axil_arb_pkg.sv - shared types and defaults for the two-requester AXI4-Lite arbiter
// Contents: FSM state enum, AXI response codes, default ADDR_W/DATA_W/TIMEOUT_CYC.
package axil_arb_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 256;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ,
        ST_RDATA,
        ST_DONE
    } state_t;

endpackage

// File: rtl/axil_req_arbiter_if.sv
// rtl/axil_req_arbiter_if.sv - AXI4-Lite master bus bundle for the request arbiter
// Modports: master (arbiter drives AW/W/AR and BREADY/RREADY), slave (the AXI4-Lite target).
interface axil_req_arbiter_if
    import axil_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] M_AXI_AWADDR;
    logic [2:0]        M_AXI_AWPROT;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY;
    logic [DATA_W-1:0] M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID;
    logic              M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID;
    logic              M_AXI_BREADY;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [2:0]        M_AXI_ARPROT;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [DATA_W-1:0] M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last_grant history
// Ports: clk, rst (sync active-high), req[1:0], en (arbitration allowed), gnt[1:0] one-hot.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // Index of the requester granted most recently; reset to 1 so that
    // requester 0 wins the first contention.
    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/axil_req_arbiter.sv
// rtl/axil_req_arbiter.sv - arbitrates two simple requesters onto one AXI4-Lite master
// Ports: ACLK, ARESET (sync active-high); req/we/addr/wdata per requester (packed, index i at
// [i*W +: W]); ack (one-cycle pulse), rdata/resp (valid with ack), grant (one-hot owner);
// m_axi (axil_req_arbiter_if.master). Optional macro AXIL_ARB_TIMEOUT_EN adds a per-state
// stall timeout that completes the transaction with SLVERR.
module axil_req_arbiter
    import axil_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef AXIL_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          ack,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          resp,
    output logic [1:0]          grant,
    axil_req_arbiter_if.master  m_axi
);

    state_t              state, state_nx, state_case;
    logic [1:0]          gnt, grant_q;
    logic                we_q, aw_done, w_done;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [1:0]          resp_q;
    logic                sel_we, aw_hs, w_hs;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arb2 u_rr_arb2 (
        .clk (ACLK),
        .rst (ARESET),
        .req (req),
        .en  (state == ST_IDLE),
        .gnt (gnt)
    );

    assign sel_we    = gnt[1] ? we[1] : we[0];
    assign sel_addr  = gnt[1] ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    assign sel_wdata = gnt[1] ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

    assign aw_hs = m_axi.M_AXI_AWVALID && m_axi.M_AXI_AWREADY;
    assign w_hs  = m_axi.M_AXI_WVALID && m_axi.M_AXI_WREADY;

    // AW and W are issued together; each drops on its own handshake.
    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = (state == ST_WRITE) && !aw_done;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = 4'hF;
    assign m_axi.M_AXI_WVALID  = (state == ST_WRITE) && !w_done;
    assign m_axi.M_AXI_BREADY  = (state == ST_WRESP);
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = (state == ST_READ);
    assign m_axi.M_AXI_RREADY  = (state == ST_RDATA);

    assign grant = grant_q;
    assign ack   = (state == ST_DONE) ? grant_q : 2'b00;
    assign resp  = (state == ST_DONE) ? resp_q : 2'b00;
    assign rdata = (state == ST_DONE && !we_q) ? rdata_q : '0;

    always_comb begin
        state_case = state;
        case (state)
            ST_IDLE:  if (gnt != 2'b00) state_case = sel_we ? ST_WRITE : ST_READ;
            ST_WRITE: if ((aw_done || aw_hs) && (w_done || w_hs)) state_case = ST_WRESP;
            ST_WRESP: if (m_axi.M_AXI_BVALID) state_case = ST_DONE;
            ST_READ:  if (m_axi.M_AXI_ARREADY) state_case = ST_RDATA;
            ST_RDATA: if (m_axi.M_AXI_RVALID) state_case = ST_DONE;
            ST_DONE:  state_case = ST_IDLE;
            default:  state_case = ST_IDLE;
        endcase
    end

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             pending, tmo_hit;

    assign pending = (state == ST_WRITE) || (state == ST_WRESP) ||
                     (state == ST_READ)  || (state == ST_RDATA);
    // A handshake landing in the final cycle still wins over the abort.
    assign tmo_hit  = pending && (state_case == state) &&
                      (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign state_nx = tmo_hit ? ST_DONE : state_case;

    always_ff @(posedge ACLK) begin
        if (ARESET || (state_nx != state)) begin
            tmo_cnt <= '0;
        end else if (pending) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign state_nx = state_case;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= ST_IDLE;
            grant_q <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        grant_q <= gnt;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        rdata_q <= '0;
                        resp_q  <= RESP_OKAY;
                    end
                end
                ST_WRITE: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                ST_WRESP: begin
                    if (m_axi.M_AXI_BVALID) resp_q <= m_axi.M_AXI_BRESP;
                end
                ST_RDATA: begin
                    if (m_axi.M_AXI_RVALID) begin
                        rdata_q <= m_axi.M_AXI_RDATA;
                        resp_q  <= m_axi.M_AXI_RRESP;
                    end
                end
                ST_DONE: grant_q <= 2'b00;
                default: ;
            endcase
`ifdef AXIL_ARB_TIMEOUT_EN
            if (tmo_hit) begin
                resp_q  <= RESP_SLVERR;
                rdata_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// tb/tb_axil_req_arbiter.sv - scoreboard bench for axil_req_arbiter
module tb_axil_req_arbiter;
    import axil_arb_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [1:0]  req, we;
    logic [63:0] addr, wdata;
    logic [1:0]  ack, resp, grant;
    logic [31:0] rdata;

    logic        awready, wready, arready, b_en, r_en;
    logic [1:0]  b_resp, r_resp;
    logic [31:0] rd_val;

    axil_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    assign bus.M_AXI_AWREADY = awready;
    assign bus.M_AXI_WREADY  = wready;
    assign bus.M_AXI_ARREADY = arready;
    assign bus.M_AXI_BVALID  = bus.M_AXI_BREADY && b_en;
    assign bus.M_AXI_BRESP   = b_resp;
    assign bus.M_AXI_RVALID  = bus.M_AXI_RREADY && r_en;
    assign bus.M_AXI_RDATA   = rd_val;
    assign bus.M_AXI_RRESP   = r_resp;

    axil_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .ack    (ack),
        .rdata  (rdata),
        .resp   (resp),
        .grant  (grant),
        .m_axi  (bus)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  ack;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge ACLK);
    endtask

    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        req[i]           = 1'b1;
        we[i]            = w;
        addr[i*32 +: 32]  = a;
        wdata[i*32 +: 32] = d;
    endtask

    task automatic expect_ack(input logic [1:0] a, input logic [31:0] d, input logic [1:0] r, input int at);
        exp_t e;
        e.ack = a; e.rdata = d; e.resp = r; e.at = at;
        sb.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, grant, 2'b00);
        check({tag, "_ack"}, ack, 2'b00);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_resp"}, resp, 2'b00);
        check({tag, "_axi_vr"}, {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                                 bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 5'b0);
    endtask

    // Monitor: every ack pulse is matched against the oldest expectation.
    always @(negedge ACLK) begin
        if (ack != 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=%b at cycle %0d, required no ack", ack, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("ack_owner", ack, mon_e.ack);
                check("ack_rdata", rdata, mon_e.rdata);
                check("ack_resp", resp, mon_e.resp);
                check("ack_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        ARESET = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        awready = 1'b1; wready = 1'b1; arready = 1'b1; b_en = 1'b1; r_en = 1'b1;
        b_resp = RESP_OKAY; r_resp = RESP_OKAY; rd_val = 32'h5A5A_0000;
        repeat (3) @(negedge ACLK);
        check_idle_outputs("reset");
        ARESET = 1'b0;
        @(negedge ACLK);

        // Both requesters hold req: 0 write, 1 read; grants alternate 0,1,0,1.
        k = cyc;
        issue(0, 1'b1, 32'h10, 32'h1111_2222);
        issue(1, 1'b0, 32'h14, 32'h0);
        expect_ack(2'b01, 32'h0, RESP_OKAY, k + 3);
        expect_ack(2'b10, 32'h5A5A_0000, RESP_OKAY, k + 7);
        expect_ack(2'b01, 32'h0, RESP_OKAY, k + 11);
        expect_ack(2'b10, 32'h5A5A_0000, RESP_OKAY, k + 15);
        wait_cyc(k + 1);  check("rr_grant_a", grant, 2'b01);
        wait_cyc(k + 4);  check("rr_idle_gap", grant, 2'b00);
        wait_cyc(k + 5);  check("rr_grant_b", grant, 2'b10);
        wait_cyc(k + 9);  check("rr_grant_c", grant, 2'b01);
        wait_cyc(k + 13); check("rr_grant_d", grant, 2'b10);
        wait_cyc(k + 15); req = '0;
        wait_cyc(k + 17);

        // Requester 0 writes 0x0101FFFF to 0x0 with an always-ready slave.
        k = cyc;
        issue(0, 1'b1, 32'h0, 32'h0101_FFFF);
        expect_ack(2'b01, 32'h0, RESP_OKAY, k + 3);
        wait_cyc(k + 1);
        check("wr_aw_w_valid", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}, 3'b110);
        check("wr_awaddr", bus.M_AXI_AWADDR, 32'h0);
        check("wr_wdata", bus.M_AXI_WDATA, 32'h0101_FFFF);
        check("wr_wstrb", bus.M_AXI_WSTRB, 4'hF);
        check("wr_prot", {bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}, 6'b0);
        wait_cyc(k + 3); req = '0;
        wait_cyc(k + 5);

        // Requester 1 reads 0x4; req dropped mid-transaction must not matter.
        k = cyc;
        rd_val = 32'hABCD_0001;
        issue(1, 1'b0, 32'h4, 32'h0);
        expect_ack(2'b10, 32'hABCD_0001, RESP_OKAY, k + 3);
        wait_cyc(k + 1);
        check("rd_arvalid", bus.M_AXI_ARVALID, 1'b1);
        check("rd_araddr", bus.M_AXI_ARADDR, 32'h4);
        req = '0;
        wait_cyc(k + 5);

        // WREADY arrives 5 cycles after AWREADY; SLVERR on B passes through.
        k = cyc;
        wready = 1'b0; b_resp = RESP_SLVERR;
        issue(0, 1'b1, 32'h20, 32'hCAFE_0039);
        expect_ack(2'b01, 32'h0, RESP_SLVERR, k + 8);
        wait_cyc(k + 1); check("split_both_valid", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID}, 2'b11);
        wait_cyc(k + 2); check("split_aw_dropped", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID}, 2'b01);
        wait_cyc(k + 5); check("split_w_held", bus.M_AXI_WVALID, 1'b1);
        wait_cyc(k + 6); wready = 1'b1;
        wait_cyc(k + 7); check("split_wresp", {bus.M_AXI_WVALID, bus.M_AXI_BREADY}, 2'b01);
        wait_cyc(k + 8); req = '0; b_resp = RESP_OKAY;
        wait_cyc(k + 10);

`ifdef AXIL_ARB_TIMEOUT_EN
        // BVALID never comes: abort with SLVERR after 256 cycles in WRESP.
        k = cyc;
        b_en = 1'b0;
        issue(0, 1'b1, 32'h30, 32'h1);
        expect_ack(2'b01, 32'h0, RESP_SLVERR, k + 2 + 256);
        wait_cyc(k + 258); req = '0; b_en = 1'b1;
        wait_cyc(k + 260);
`endif

        // Reset while waiting in RDATA, then a fresh contention.
        k = cyc;
        r_en = 1'b0;
        issue(1, 1'b0, 32'h44, 32'h0);
        wait_cyc(k + 2);
        check("rst_in_rdata", bus.M_AXI_RREADY, 1'b1);
        ARESET = 1'b1; req = '0;
        wait_cyc(k + 3);
        check_idle_outputs("midrst");
        ARESET = 1'b0; r_en = 1'b1; rd_val = 32'h1234_5678;
        @(negedge ACLK);
        k = cyc;
        issue(0, 1'b0, 32'h8, 32'h0);
        issue(1, 1'b0, 32'hC, 32'h0);
        expect_ack(2'b01, 32'h1234_5678, RESP_OKAY, k + 3);
        expect_ack(2'b10, 32'h1234_5678, RESP_OKAY, k + 7);
        wait_cyc(k + 1); check("post_rst_grant", grant, 2'b01);
        wait_cyc(k + 7); req = '0;
        wait_cyc(k + 10);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
